// File: rtl/aclk_defs_pkg.sv
// aclk_defs_pkg: scanner state encoding and keypad code map shared by the aclk keypad front end
package aclk_defs_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_e;
  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_D = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  // nibble at index {row, col} is the code printed on that key
  localparam logic [63:0] KEY_MAP = {
    KEY_D, KEY_HASH, 4'd0, KEY_STAR,
    KEY_C, 4'd9, 4'd8, 4'd7,
    KEY_B, 4'd6, 4'd5, 4'd4,
    KEY_A, 4'd3, 4'd2, 4'd1
  };
  function automatic logic [1:0] hot_idx(input logic [3:1] v);
    return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/aclk_stable_counter.sv
// aclk_stable_counter: saturating run-length counter, clear wins over enable, tc flags the step onto MAX
module aclk_stable_counter #(
  parameter int MAX = 3,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = en_i && cnt_q == W'(MAX - 1);
endmodule

// File: rtl/aclk_keyscan.sv
// aclk_keyscan: 4x4 keypad scanner/debouncer; shift feeds aclk_keyreg, func feeds the alarm controller.
// Define ACLK_KEYSCAN_AUTO_REPEAT_EN to re-issue shift while a digit key stays held.
module aclk_keyscan
  import aclk_defs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DWELL = 1,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       shift,
  output logic       func,
  output logic       busy
);
  localparam int DW = $clog2(SCAN_DWELL + 1);
  if (DEBOUNCE_CYCLES < 2 || SCAN_DWELL < 1 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("aclk_keyscan: parameter out of range");
  end
  state_e state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d, key_q, key_d, code;
  logic [DW-1:0] dwell_q, dwell_d;
  logic shift_q, shift_d, func_q, func_d, busy_q;
  logic match, deb_tc, rel_tc, rpt_fire;
  assign match = row == row_q;
  assign code = key_code(hot_idx(row_q[3:1]), hot_idx(col_q[3:1]));
  aclk_stable_counter #(.MAX(DEBOUNCE_CYCLES - 1)) u_deb (
    .clock(clock), .reset(reset),
    .clr_i(state_q != DEBOUNCE || !match), .en_i(match), .tc_o(deb_tc)
  );
  // the first zero is sampled inside WAIT_RELEASE, so the release run needs one more step
  aclk_stable_counter #(.MAX(DEBOUNCE_CYCLES)) u_rel (
    .clock(clock), .reset(reset),
    .clr_i(state_q != WAIT_RELEASE || row != 4'd0), .en_i(row == 4'd0), .tc_o(rel_tc)
  );
`ifdef ACLK_KEYSCAN_AUTO_REPEAT_EN
  logic rpt_tc;
  aclk_stable_counter #(.MAX(REPEAT_CYCLES)) u_rpt (
    .clock(clock), .reset(reset),
    .clr_i(state_q != WAIT_RELEASE || !match || rpt_tc), .en_i(match), .tc_o(rpt_tc)
  );
  assign rpt_fire = rpt_tc && state_q == WAIT_RELEASE && key_q < 4'd10;
`else
  assign rpt_fire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    dwell_d = dwell_q;
    key_d = key_q;
    shift_d = 1'b0;
    func_d = 1'b0;
    case (state_q)
      SCAN:
        if ($onehot(row)) begin
          state_d = DEBOUNCE;
          row_d = row;
          dwell_d = '0;
        end else if (dwell_q == DW'(SCAN_DWELL - 1)) begin
          col_d = {col_q[2:0], col_q[3]};
          dwell_d = '0;
        end else dwell_d = dwell_q + 1'b1;
      DEBOUNCE:
        if (!match) begin
          state_d = SCAN;
          col_d = {col_q[2:0], col_q[3]};
        end else if (deb_tc) state_d = EMIT;
      EMIT: begin
        key_d = code;
        shift_d = code < 4'd10;
        func_d = code >= 4'd10;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        shift_d = rpt_fire;
        if (rel_tc) begin
          state_d = SCAN;
          col_d = 4'b0001;
        end
      end
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= SCAN;
      col_q <= 4'b0001;
      row_q <= '0;
      dwell_q <= '0;
      key_q <= '0;
      shift_q <= 1'b0;
      func_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      dwell_q <= dwell_d;
      key_q <= key_d;
      shift_q <= shift_d;
      func_q <= func_d;
      busy_q <= state_d != SCAN;
    end
  assign col = col_q;
  assign key = key_q;
  assign shift = shift_q;
  assign func = func_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_aclk_keyscan.sv
// tb_aclk_keyscan: randomized and directed keypad stimulus against a keypad-level model of aclk_keyscan
module tb_aclk_keyscan;
  localparam int DEB = 4;
  localparam int DWELL = 1;
  localparam int REP = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row = 4'd0;
  logic [3:0] col, key;
  logic shift, func, busy;
  int n_vec = 0, n_err = 0;
  int n_shift = 0, n_func = 0;
  logic [3:0] keys_q[$];
  int lut [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  int m_pos, m_dwell, m_run, m_zeros, m_hold;
  bit m_locked, m_acc, m_emit, m_shift, m_func, prev_strobe;
  logic [3:0] m_pat, m_key;

  aclk_keyscan #(.DEBOUNCE_CYCLES(DEB), .SCAN_DWELL(DWELL), .REPEAT_CYCLES(REP)) dut (
    .clock(clock), .reset(reset), .row(row), .col(col), .key(key),
    .shift(shift), .func(func), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dwell = 0; m_run = 0; m_zeros = 0; m_hold = 0;
    m_locked = 0; m_acc = 0; m_emit = 0; m_shift = 0; m_func = 0;
    m_pat = 0; m_key = 0; prev_strobe = 0;
  endtask

  // predicts the registered outputs after the next clock edge given the row sampled there
  task automatic model_step(input logic [3:0] r);
    m_shift = 0;
    m_func = 0;
    if (m_emit) begin
      m_key = 4'(lut[$clog2(m_pat)][m_pos]);
      m_shift = m_key < 10;
      m_func = !m_shift;
      m_emit = 0; m_acc = 1; m_zeros = 0; m_hold = 0;
    end else if (!m_locked) begin
      if ($countones(r) == 1) begin
        m_locked = 1; m_pat = r; m_run = 1; m_dwell = 0;
      end else begin
        m_dwell = m_dwell + 1;
        if (m_dwell == DWELL) begin m_dwell = 0; m_pos = (m_pos + 1) % 4; end
      end
    end else if (!m_acc) begin
      if (r == m_pat) begin
        m_run = m_run + 1;
        if (m_run == DEB) m_emit = 1;
      end else begin
        m_locked = 0; m_pos = (m_pos + 1) % 4;
      end
    end else begin
      m_zeros = (r == 0) ? m_zeros + 1 : 0;
      m_hold = (r == m_pat) ? m_hold + 1 : 0;
`ifdef ACLK_KEYSCAN_AUTO_REPEAT_EN
      if (m_hold > 0 && m_hold % REP == 0 && m_key < 10) m_shift = 1;
`endif
      if (m_zeros == DEB) begin
        m_locked = 0; m_acc = 0; m_pos = 0; m_dwell = 0; m_zeros = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("col", col, 32'(1 << m_pos));
    chk("key", key, m_key);
    chk("shift", shift, m_shift);
    chk("func", func, m_func);
    chk("busy", busy, m_locked);
    chk("strobe_excl", {shift & func, (shift | func) & prev_strobe}, 0);
    prev_strobe = shift | func;
  endtask

  task automatic cycle(input logic [3:0] r);
    row = r;
    model_step(r);
    @(posedge clock);
    @(negedge clock);
    check_all();
    if (shift) begin n_shift++; keys_q.push_back(key); end
    if (func) n_func++;
  endtask

  task automatic press(input int ri, input int ci, input int hold, input int rel);
    int w = 0;
    while ((m_locked || m_pos != ci) && w < 64) begin cycle(4'd0); w++; end
    chk("press_wait_bound", w < 64, 1);
    repeat (hold) cycle(4'(1 << ri));
    repeat (rel) cycle(4'd0);
  endtask

  task automatic clear_counts();
    n_shift = 0; n_func = 0; keys_q.delete();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] exp_rot [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] chain [4] = '{4'd1, 4'd6, 4'd2, 4'd1};
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin cycle(4'd0); chk("rotate", col, exp_rot[i]); end

    clear_counts();
    press(1, 2, 10, 6);
    chk("six_shift_n", n_shift, 1);
    chk("six_key", key, 6);
    clear_counts();
    press(0, 0, 6, 5); press(1, 2, 6, 5); press(0, 1, 6, 5); press(0, 0, 6, 5);
    chk("chain_n", keys_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("chain_key", i < keys_q.size() ? 32'(keys_q[i]) : 32'hFFFF_FFFF, chain[i]);

    clear_counts();
    press(1, 2, 2, 1);
    chk("bounce_early", n_shift + n_func, 0);
    repeat (8) cycle(4'b0010);
    repeat (6) cycle(4'd0);
    chk("bounce_n", n_shift + n_func, 1);

    clear_counts();
    press(0, 3, 6, 6);
    chk("a_func_n", n_func, 1);
    chk("a_shift_n", n_shift, 0);
    chk("a_key", key, 10);

    clear_counts();
    repeat (8) cycle(4'b0011);
    chk("multi_n", n_shift + n_func, 0);
    press(2, 0, 3, 6);
    chk("short_n", n_shift + n_func, 0);
    press(2, 0, 6, 3);
    chk("rel_busy_hold", busy, 1);
    cycle(4'd0);
    chk("rel_busy_done", busy, 0);
    chk("rel_col", col, 4'b0001);

    clear_counts();
    press(1, 1, 2, 0);
    reset = 1'b0;
    #1;
    chk("arst_col", col, 4'b0001);
    chk("arst_key", key, 0);
    chk("arst_strobe", {shift, func}, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check_all();
    chk("arst_no_strobe", n_shift + n_func, 0);
    press(1, 1, 40, 6);
`ifdef ACLK_KEYSCAN_AUTO_REPEAT_EN
    chk("hold5_n", n_shift, 3);
`else
    chk("hold5_n", n_shift, 1);
`endif
    chk("hold5_key", key, 5);

    repeat (120) begin
      int k = $urandom_range(0, 9);
      if (k < 4) r = 4'(1 << $urandom_range(0, 3));
      else if (k < 6) begin
        do r = 4'($urandom_range(3, 15)); while ($countones(r) < 2);
      end else r = 4'd0;
      repeat ($urandom_range(1, 8)) cycle(r);
    end
    repeat (20) press($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 12), $urandom_range(1, 8));
    repeat (8) cycle(4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
